// File: rtl/fifo_lib_pkg.sv
// Shared FIFO-library types: write-arbiter FSM state and common helpers.
package fifo_lib_pkg;

   typedef enum logic {
      WR_IDLE  = 1'b0,
      WR_BURST = 1'b1
   } wr_state_e;

endpackage : fifo_lib_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after last_gnt, wrapping.
module rr_picker #(
   parameter int REQ_CNT = 4,
   parameter int IW      = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
   input  logic [REQ_CNT-1:0] req,
   input  logic [IW-1:0]      last_gnt,
   output logic [REQ_CNT-1:0] pick
);

   always_comb begin
      int idx;
      idx  = 0;
      pick = '0;
      // last_gnt itself is visited last, so the requester just served has lowest priority
      for (int k = 1; k <= REQ_CNT; k++) begin
         idx = (int'(last_gnt) + k) % REQ_CNT;
         if (pick == '0 && req[idx])
            pick[idx] = 1'b1;
      end
   end

endmodule : rr_picker

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port from REQ_CNT requesters.
module fifo_wr_arb
   import fifo_lib_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int REQ_CNT    = 4,
   parameter int BURST_LEN  = 4,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                              wr_clk_i,
   input  logic                              rst_i,
   input  logic [REQ_CNT-1:0]                req_valid_i,
   input  logic [REQ_CNT-1:0][DATA_WIDTH-1:0] req_data_i,
   output logic [REQ_CNT-1:0]                req_ready_o,
   input  logic                              wr_full_i,
   input  logic [ADDR_WIDTH:0]               wr_used_words_i,
   output logic [DATA_WIDTH-1:0]             wr_data_o,
   output logic                              wr_o,
   output logic [REQ_CNT-1:0]                gnt_o,
   output logic                              busy_o
);

   localparam int IW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);

   wr_state_e            state_q;
   logic [REQ_CNT-1:0]   gnt_q;
   logic [IW-1:0]        last_gnt_q;
   logic [CW-1:0]        burst_cnt_q;
   logic [REQ_CNT-1:0]   pick;
   logic [IW-1:0]        pick_idx;
   logic                 busy;
   logic                 cur_valid;
   logic                 unused_used_words;

   // Occupancy is only observed for status; it never gates a transfer.
   assign unused_used_words = ^wr_used_words_i;

   rr_picker #(.REQ_CNT(REQ_CNT), .IW(IW)) u_picker (
      .req      (req_valid_i),
      .last_gnt (last_gnt_q),
      .pick     (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < REQ_CNT; i++)
         if (pick[i]) pick_idx = IW'(i);
   end

   // last_gnt equals the active grant while in BURST, so it doubles as the mux select.
   assign busy        = (state_q == WR_BURST);
   assign cur_valid   = req_valid_i[last_gnt_q];
   assign req_ready_o = (busy && !wr_full_i) ? gnt_q : '0;
   assign wr_o        = busy && cur_valid && !wr_full_i;
   assign wr_data_o   = busy ? req_data_i[last_gnt_q] : '0;
   assign gnt_o       = gnt_q;
   assign busy_o      = busy;

   always_ff @(posedge wr_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= WR_IDLE;
         gnt_q       <= '0;
         last_gnt_q  <= IW'(REQ_CNT - 1);
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            WR_IDLE: begin
               if (|req_valid_i && !wr_full_i) begin
                  state_q     <= WR_BURST;
                  gnt_q       <= pick;
                  last_gnt_q  <= pick_idx;
                  burst_cnt_q <= '0;
               end
            end
            WR_BURST: begin
               if (wr_o) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
                  if (burst_cnt_q == CW'(BURST_LEN - 1)) begin
                     state_q <= WR_IDLE;
                     gnt_q   <= '0;
                  end
               end else if (!cur_valid) begin
                  state_q <= WR_IDLE;
                  gnt_q   <= '0;
               end
            end
            default: begin
               state_q <= WR_IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// Directed cycle-table bench for fifo_wr_arb with default parameters.
module tb_fifo_wr_arb;

   logic             wr_clk_i = 1'b0;
   logic             rst_i    = 1'b1;
   logic [3:0]       req_valid_i = '0;
   logic [3:0][7:0]  req_data_i;
   logic [3:0]       req_ready_o;
   logic             wr_full_i = 1'b0;
   logic [3:0]       wr_used_words_i = 4'd2;
   logic [7:0]       wr_data_o;
   logic             wr_o;
   logic [3:0]       gnt_o;
   logic             busy_o;

   int checks = 0;
   int errors = 0;
   int words  = 0;

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic       full;
      logic [3:0] rdy;
      logic       wr;
      logic [3:0] gnt;
      logic       busy;
      logic [7:0] data;
   } row_t;

   row_t rows[$];

   fifo_wr_arb #(.DATA_WIDTH(8), .REQ_CNT(4), .BURST_LEN(4), .ADDR_WIDTH(3)) dut (
      .wr_clk_i        (wr_clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_data_i      (req_data_i),
      .req_ready_o     (req_ready_o),
      .wr_full_i       (wr_full_i),
      .wr_used_words_i (wr_used_words_i),
      .wr_data_o       (wr_data_o),
      .wr_o            (wr_o),
      .gnt_o           (gnt_o),
      .busy_o          (busy_o)
   );

   always #5 wr_clk_i = ~wr_clk_i;

   // Invariants sampled every cycle.
   always @(negedge wr_clk_i) begin
      if (!busy_o) words = 0;
      else if (wr_o) words++;
      checks++;
      if (!$onehot0(gnt_o) || $countones(req_ready_o) > 1 || (wr_o && wr_full_i) || words > 4) begin
         errors++;
         $display("FAIL invariant t=%0t gnt=%b ready=%b wr=%b full=%b words=%0d",
                  $time, gnt_o, req_ready_o, wr_o, wr_full_i, words);
      end
   end

   function automatic row_t r(logic rst, logic [3:0] valid, logic full, logic [3:0] rdy,
                              logic wr, logic [3:0] gnt, logic busy, logic [7:0] data);
      row_t x;
      x.rst = rst; x.valid = valid; x.full = full; x.rdy = rdy;
      x.wr = wr; x.gnt = gnt; x.busy = busy; x.data = data;
      return x;
   endfunction

   // Leaves the bench 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      rst_i = 1'b1; req_valid_i = '0; wr_full_i = 1'b0;
      @(negedge wr_clk_i);
      checks++;
      if (req_ready_o !== 4'b0 || wr_o !== 1'b0 || gnt_o !== 4'b0 || busy_o !== 1'b0 || wr_data_o !== 8'h0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b wr=%b gnt=%b busy=%b data=%h want all zero",
                  req_ready_o, wr_o, gnt_o, busy_o, wr_data_o);
      end
      @(posedge wr_clk_i); #1;
      rst_i = 1'b0;
   endtask

   task automatic apply(input row_t x, input int n);
      if (x.rst) do_reset();
      req_valid_i = x.valid; wr_full_i = x.full;
      @(negedge wr_clk_i);
      checks++;
      if (req_ready_o !== x.rdy || wr_o !== x.wr || gnt_o !== x.gnt || busy_o !== x.busy ||
          (x.wr && wr_data_o !== x.data)) begin
         errors++;
         $display("FAIL row%0d got rdy=%b wr=%b gnt=%b busy=%b data=%h want rdy=%b wr=%b gnt=%b busy=%b data=%h",
                  n, req_ready_o, wr_o, gnt_o, busy_o, wr_data_o, x.rdy, x.wr, x.gnt, x.busy, x.data);
      end
      @(posedge wr_clk_i); #1;
   endtask

   initial begin
      logic [3:0] g1;
      for (int i = 0; i < 4; i++) req_data_i[i] = 8'(8'hA0 + i);

      // Single requester 2, three words, then valid drops.
      rows.push_back(r(1, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));
      for (int i = 0; i < 3; i++) rows.push_back(r(0, 4'b0100, 0, 4'b0100, 1, 4'b0100, 1, 8'hA2));
      rows.push_back(r(0, 4'b0000, 0, 4'b0100, 0, 4'b0100, 1, 8'h00));
      rows.push_back(r(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));

      // All requesters valid: grants 0,1,2,3,0 with full bursts and one idle cycle each.
      for (int b = 0; b < 5; b++) begin
         g1 = 4'b0001 << (b % 4);
         rows.push_back(r(b == 0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));
         for (int w = 0; w < 4; w++)
            rows.push_back(r(0, 4'b1111, 0, g1, 1, g1, 1, 8'(8'hA0 + (b % 4))));
      end
      rows.push_back(r(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));

      // Full stalls mid-burst, grant held; full while idle blocks arbitration.
      rows.push_back(r(1, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));
      for (int i = 0; i < 2; i++) rows.push_back(r(0, 4'b0001, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0));
      for (int i = 0; i < 5; i++) rows.push_back(r(0, 4'b0001, 1, 4'b0000, 0, 4'b0001, 1, 8'h00));
      for (int i = 0; i < 2; i++) rows.push_back(r(0, 4'b0001, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0));
      for (int i = 0; i < 2; i++) rows.push_back(r(0, 4'b0001, 1, 4'b0000, 0, 4'b0000, 0, 8'h00));
      rows.push_back(r(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));
      rows.push_back(r(0, 4'b0001, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0));

      // Requester 1 ends early after one word; requester 2 next, unaffected by new valids.
      rows.push_back(r(1, 4'b0110, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));
      rows.push_back(r(0, 4'b0110, 0, 4'b0010, 1, 4'b0010, 1, 8'hA1));
      rows.push_back(r(0, 4'b0100, 0, 4'b0010, 0, 4'b0010, 1, 8'h00));
      rows.push_back(r(0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0, 8'h00));
      rows.push_back(r(0, 4'b0111, 0, 4'b0100, 1, 4'b0100, 1, 8'hA2));

      foreach (rows[i]) apply(rows[i], i);

      // Asynchronous reset during the third word of a requester-0 burst.
      do_reset();
      apply(r(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 8'h00), 100);
      apply(r(0, 4'b1111, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0), 101);
      apply(r(0, 4'b1111, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0), 102);
      #2;
      checks++;
      if (wr_o !== 1'b1 || gnt_o !== 4'b0001) begin
         errors++;
         $display("FAIL third_word got wr=%b gnt=%b want wr=1 gnt=0001", wr_o, gnt_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if (wr_o !== 1'b0 || req_ready_o !== 4'b0 || gnt_o !== 4'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got wr=%b rdy=%b gnt=%b busy=%b want 0 0000 0000 0",
                  wr_o, req_ready_o, gnt_o, busy_o);
      end
      @(posedge wr_clk_i); #1;
      rst_i = 1'b0;
      apply(r(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0, 8'h00), 103);
      apply(r(0, 4'b1111, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0), 104);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_wr_arb

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of each requester and the FIFO write port.
REQ-002 Parameter REQ_CNT, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter BURST_LEN, default 4, maximum words accepted per grant; legal range 1..256.
REQ-004 Parameter ADDR_WIDTH, default 3, FIFO address width; FIFO capacity is 2**ADDR_WIDTH.
REQ-005 wr_clk_i  input  1  FIFO write-domain clock; all logic is on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 req_valid_i  input  REQ_CNT  per-requester word-valid.
REQ-008 req_data_i  input  REQ_CNT x DATA_WIDTH  per-requester data, packed; index i belongs to requester i.
REQ-009 req_ready_o  output  REQ_CNT  per-requester accept; a word transfers when valid and ready are both high.
REQ-010 wr_full_i  input  1  FIFO write-side full flag.
REQ-011 wr_used_words_i  input  ADDR_WIDTH+1  FIFO write-side occupancy; monitored only, exported as status.
REQ-012 wr_data_o  output  DATA_WIDTH  FIFO write data.
REQ-013 wr_o  output  1  FIFO write strobe.
REQ-014 gnt_o  output  REQ_CNT  one-hot current grant; zero when idle.
REQ-015 busy_o  output  1  high while in BURST.

Function
REQ-016 The block SHALL use a two-state FSM: IDLE and BURST.
REQ-017 In IDLE with any req_valid_i bit high and wr_full_i low, the block SHALL select the first valid requester in round-robin order starting at last_gnt+1 (mod REQ_CNT), register it as gnt, clear burst_cnt, and enter BURST on the next edge.
REQ-018 In IDLE, req_ready_o SHALL be all-zero and wr_o SHALL be low; arbitration costs exactly one idle cycle per grant.
REQ-019 In BURST, req_ready_o[gnt] SHALL equal !wr_full_i and all other ready bits SHALL be zero.
REQ-020 wr_o SHALL equal req_valid_i[gnt] && req_ready_o[gnt], combinationally; wr_data_o SHALL equal req_data_i[gnt] (zero latency).
REQ-021 Each accepted word SHALL increment burst_cnt; the acceptance that makes the count reach BURST_LEN SHALL return the FSM to IDLE on that edge.
REQ-022 In BURST, if req_valid_i[gnt] is low for one cycle, the FSM SHALL return to IDLE on that edge (early burst end).
REQ-023 wr_full_i high in BURST SHALL stall the transfer without losing the grant or changing burst_cnt.
REQ-024 last_gnt SHALL update to gnt when entering BURST; a requester just served SHALL have lowest priority in the next arbitration.
REQ-025 burst_cnt SHALL be $clog2(BURST_LEN+1) bits wide and never wrap.
REQ-026 At most one requester SHALL ever see ready high in any cycle; gnt_o SHALL be one-hot or zero.
REQ-027 Requester valid changes during another requester's burst SHALL NOT affect the current grant.

Reset
REQ-028 On rst_i high, the FSM SHALL enter IDLE, gnt, burst_cnt and outputs SHALL be zero, and last_gnt SHALL be REQ_CNT-1 so that requester 0 wins first.
REQ-029 Reset asserted mid-burst SHALL drop wr_o and all ready bits immediately (asynchronously); no partial word SHALL be written after release.

Structure
REQ-030 The FSM state enum SHALL live in the shared fifo_lib_pkg package alongside other FIFO-library typedefs.
REQ-031 The round-robin picker SHALL be a separate combinational sub-module rr_picker (inputs: request vector, last grant; output: one-hot pick); the top-level instantiates it once.

Verification
REQ-032 Reset release, only req 2 valid with 3 words -> one idle cycle, gnt_o=4'b0100, three wr_o pulses, then IDLE after valid drops.
REQ-033 All four requesters continuously valid, BURST_LEN=4 -> grant order 0,1,2,3,0; exactly 4 words per burst; one idle cycle between bursts.
REQ-034 wr_full_i asserted for 5 cycles mid-burst after 2 words -> ready low, no wr_o, then remaining 2 words after full drops, same grant held.
REQ-035 req 1 drops valid after 1 word of a 4-word burst -> FSM returns to IDLE, next grant goes to req 2 if valid.
REQ-036 rst_i pulsed during the third word of a burst -> wr_o low asynchronously, after release requester 0 is granted first.
REQ-037 Assertions, all tests: gnt_o one-hot or zero; popcount(req_ready_o) <= 1; wr_o implies !wr_full_i; words per burst <= BURST_LEN.
